hazard3_muldiv_arb: RTL and testbench

//  Round-robin arbiter sharing one hazard3_muldiv_seq between N_REQ requesters (harts/coprocessors).

---
 rtl/hazard3_muldiv_arb.sv | 246 ++++++++++++++++++++++++
 tb/tb_hazard3_muldiv_arb.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard3_muldiv_arb.sv
// hazard3_muldiv_arb
//   Round-robin arbiter that shares a single sequential muldiv unit
//   (hazard3_muldiv_seq) between N_REQ requesters. It grants one op at a
//   time and remembers which requester owns it. A kill from the owner is
//   forwarded to the unit. The result is returned to the owner only.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_vld/req_rdy          per-requester request handshake
//   req_op/req_a/req_b       packed per-requester op and operands
//   req_kill                 per-requester abandon of the in-flight op
//   resp_vld                 one-cycle one-hot result pulse to the owner
//   resp_h/resp_l            result halves; held until the next response
//   md_op*                   issue/kill side towards the muldiv unit
//   md_op_rdy, md_result_*   status/result side from the muldiv unit
//
// Build option
//   HAZARD3_MULDIV_ARB_REUSE_EN: when defined, a one-entry result cache lets
//   MUL after MULH*, and DIV/REM or DIVU/REMU pairs with the same operands,
//   complete without re-issuing to the muldiv unit.
module hazard3_muldiv_arb #(
  parameter int N_REQ   = 2,
  parameter int W_DATA  = 32,
  parameter int W_MULOP = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_vld,
  output logic [N_REQ-1:0]           req_rdy,
  input  logic [N_REQ*W_MULOP-1:0]   req_op,
  input  logic [N_REQ*W_DATA-1:0]    req_a,
  input  logic [N_REQ*W_DATA-1:0]    req_b,
  input  logic [N_REQ-1:0]           req_kill,
  output logic [N_REQ-1:0]           resp_vld,
  output logic [W_DATA-1:0]          resp_h,
  output logic [W_DATA-1:0]          resp_l,
  output logic [W_MULOP-1:0]         md_op,
  output logic                       md_op_vld,
  output logic                       md_op_kill,
  output logic [W_DATA-1:0]          md_op_a,
  output logic [W_DATA-1:0]          md_op_b,
  input  logic                       md_op_rdy,
  input  logic                       md_result_vld,
  input  logic [W_DATA-1:0]          md_result_h,
  input  logic [W_DATA-1:0]          md_result_l
);

  localparam int IDXW = $clog2(N_REQ);

  // BUSY_FIRST exists because the muldiv unit only drops rdy one cycle
  // after issue; its result_vld is not trusted in that cycle.
  typedef enum logic [1:0] {S_IDLE, S_BUSY_FIRST, S_BUSY} state_t;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDXW-1:0]   owner_q, owner_d;
  logic [N_REQ-1:0]  resp_vld_q, resp_vld_d;
  logic [W_DATA-1:0] resp_h_q, resp_h_d;
  logic [W_DATA-1:0] resp_l_q, resp_l_d;

  logic [N_REQ-1:0]   eligible;
  logic               found;
  int                 idx;
  logic [IDXW-1:0]    winner;
  logic [IDXW-1:0]    next_ptr;
  logic [W_MULOP-1:0] winner_op;
  logic [W_DATA-1:0]  winner_a;
  logic [W_DATA-1:0]  winner_b;

  function automatic logic [N_REQ-1:0] onehot(input logic [IDXW-1:0] i);
    onehot = N_REQ'(1) << i;
  endfunction

`ifdef HAZARD3_MULDIV_ARB_REUSE_EN
  localparam logic [W_MULOP-1:0] M_OP_MUL    = W_MULOP'(0);
  localparam logic [W_MULOP-1:0] M_OP_MULH   = W_MULOP'(1);
  localparam logic [W_MULOP-1:0] M_OP_MULHSU = W_MULOP'(2);
  localparam logic [W_MULOP-1:0] M_OP_MULHU  = W_MULOP'(3);
  localparam logic [W_MULOP-1:0] M_OP_DIV    = W_MULOP'(4);
  localparam logic [W_MULOP-1:0] M_OP_DIVU   = W_MULOP'(5);
  localparam logic [W_MULOP-1:0] M_OP_REM    = W_MULOP'(6);
  localparam logic [W_MULOP-1:0] M_OP_REMU   = W_MULOP'(7);

  // Results depend only on op and operands, so any requester may hit.
  logic               cache_vld_q, cache_vld_d;
  logic [W_MULOP-1:0] cache_op_q, cache_op_d;
  logic [W_DATA-1:0]  cache_a_q, cache_a_d, cache_b_q, cache_b_d;
  logic [W_DATA-1:0]  cache_h_q, cache_h_d, cache_l_q, cache_l_d;
  logic               pair_ok, hit;

  always_comb begin
    pair_ok = 1'b0;
    if (winner_op == M_OP_MUL)
      pair_ok = (cache_op_q == M_OP_MUL) || (cache_op_q == M_OP_MULH) ||
                (cache_op_q == M_OP_MULHSU) || (cache_op_q == M_OP_MULHU);
    else if ((winner_op == M_OP_DIV) || (winner_op == M_OP_REM))
      pair_ok = (cache_op_q == M_OP_DIV) || (cache_op_q == M_OP_REM);
    else if ((winner_op == M_OP_DIVU) || (winner_op == M_OP_REMU))
      pair_ok = (cache_op_q == M_OP_DIVU) || (cache_op_q == M_OP_REMU);
    hit = cache_vld_q && found && pair_ok &&
          (winner_a == cache_a_q) && (winner_b == cache_b_q);
  end
`endif

  // Round-robin pick: first eligible requester at or after rr_ptr.
  always_comb begin
    eligible  = req_vld & ~req_kill;
    found     = 1'b0;
    winner    = '0;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && eligible[IDXW'(idx)]) begin
        found  = 1'b1;
        winner = IDXW'(idx);
      end
    end
    winner_op = '0;
    winner_a  = '0;
    winner_b  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (IDXW'(i) == winner) begin
        winner_op = req_op[i*W_MULOP +: W_MULOP];
        winner_a  = req_a[i*W_DATA +: W_DATA];
        winner_b  = req_b[i*W_DATA +: W_DATA];
      end
    end
    next_ptr = (winner == IDXW'(N_REQ - 1)) ? '0 : winner + 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    resp_vld_d = '0;
    resp_h_d   = resp_h_q;
    resp_l_d   = resp_l_q;
    req_rdy    = '0;
    md_op_vld  = 1'b0;
    md_op_kill = 1'b0;
    md_op      = winner_op;
    md_op_a    = winner_a;
    md_op_b    = winner_b;
`ifdef HAZARD3_MULDIV_ARB_REUSE_EN
    cache_vld_d = cache_vld_q;
    cache_op_d  = cache_op_q;
    cache_a_d   = cache_a_q;
    cache_b_d   = cache_b_q;
    cache_h_d   = cache_h_q;
    cache_l_d   = cache_l_q;
`endif
    case (state_q)
      S_IDLE: begin
`ifdef HAZARD3_MULDIV_ARB_REUSE_EN
        if (hit) begin
          req_rdy    = onehot(winner);
          resp_vld_d = onehot(winner);
          resp_h_d   = cache_h_q;
          resp_l_d   = cache_l_q;
          rr_ptr_d   = next_ptr;
        end else
`endif
        if (found) begin
          md_op_vld = 1'b1;
          if (md_op_rdy) begin
            req_rdy  = onehot(winner);
            owner_d  = winner;
            rr_ptr_d = next_ptr;
            state_d  = S_BUSY_FIRST;
`ifdef HAZARD3_MULDIV_ARB_REUSE_EN
            cache_vld_d = 1'b0;
            cache_op_d  = winner_op;
            cache_a_d   = winner_a;
            cache_b_d   = winner_b;
`endif
          end
        end
      end
      S_BUSY_FIRST, S_BUSY: begin
        // Kill takes priority over a completing result.
        if (req_kill[owner_q]) begin
          md_op_kill = 1'b1;
          state_d    = S_IDLE;
`ifdef HAZARD3_MULDIV_ARB_REUSE_EN
          cache_vld_d = 1'b0;
`endif
        end else if ((state_q == S_BUSY) && md_result_vld) begin
          resp_vld_d = onehot(owner_q);
          resp_h_d   = md_result_h;
          resp_l_d   = md_result_l;
          state_d    = S_IDLE;
`ifdef HAZARD3_MULDIV_ARB_REUSE_EN
          cache_vld_d = 1'b1;
          cache_h_d   = md_result_h;
          cache_l_d   = md_result_l;
`endif
        end else begin
          state_d = S_BUSY;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Keep the handshake side quiet while reset is asserted.
    if (rst) begin
      req_rdy    = '0;
      md_op_vld  = 1'b0;
      md_op_kill = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      resp_vld_q <= '0;
      resp_h_q   <= '0;
      resp_l_q   <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      resp_vld_q <= resp_vld_d;
      resp_h_q   <= resp_h_d;
      resp_l_q   <= resp_l_d;
    end
  end

`ifdef HAZARD3_MULDIV_ARB_REUSE_EN
  always_ff @(posedge clk) begin
    if (rst) cache_vld_q <= 1'b0;
    else     cache_vld_q <= cache_vld_d;
    cache_op_q <= cache_op_d;
    cache_a_q  <= cache_a_d;
    cache_b_q  <= cache_b_d;
    cache_h_q  <= cache_h_d;
    cache_l_q  <= cache_l_d;
  end
`endif

  assign resp_vld = resp_vld_q;
  assign resp_h   = resp_h_q;
  assign resp_l   = resp_l_q;

endmodule

// File: tb/tb_hazard3_muldiv_arb.sv
module tb_hazard3_muldiv_arb;
  localparam int N = 2, W = 32, OW = 3, LAT = 8;
  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
  localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]    req_vld, req_rdy, req_kill, resp_vld;
  logic [N*OW-1:0] req_op;
  logic [N*W-1:0]  req_a, req_b;
  logic [W-1:0]    resp_h, resp_l, md_op_a, md_op_b;
  logic [OW-1:0]   md_op;
  logic            md_op_vld, md_op_kill, md_op_rdy;
  logic            md_result_vld = 1'b0;
  logic [W-1:0]    md_result_h = '0, md_result_l = '0;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  hazard3_muldiv_arb #(.N_REQ(N), .W_DATA(W), .W_MULOP(OW)) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_kill(req_kill),
    .resp_vld(resp_vld), .resp_h(resp_h), .resp_l(resp_l),
    .md_op(md_op), .md_op_vld(md_op_vld), .md_op_kill(md_op_kill),
    .md_op_a(md_op_a), .md_op_b(md_op_b), .md_op_rdy(md_op_rdy),
    .md_result_vld(md_result_vld), .md_result_h(md_result_h), .md_result_l(md_result_l)
  );

  // Behavioural sequential muldiv: fixed latency, killable, {h,l} result.
  function automatic logic [63:0] calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ae, be;
    ae = (op == MULHU) ? {32'h0, a} : {{32{a[31]}}, a};
    be = (op == MULHU || op == MULHSU) ? {32'h0, b} : {{32{b[31]}}, b};
    case (op)
      DIV, REM:   calc = {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
      DIVU, REMU: calc = {a % b, a / b};
      default:    calc = ae * be;
    endcase
  endfunction

  logic busy_m = 1'b0;
  int   cnt_m = 0;
  logic [2:0]  op_m;
  logic [31:0] a_m, b_m;
  assign md_op_rdy = ~busy_m;

  always @(posedge clk) begin
    md_result_vld <= 1'b0;
    if (rst) begin
      busy_m <= 1'b0;
    end else if (busy_m) begin
      if (md_op_kill) busy_m <= 1'b0;
      else if (cnt_m == 1) begin
        busy_m <= 1'b0;
        md_result_vld <= 1'b1;
        {md_result_h, md_result_l} <= calc(op_m, a_m, b_m);
      end else cnt_m <= cnt_m - 1;
    end else if (md_op_vld) begin
      busy_m <= 1'b1;
      cnt_m  <= LAT;
      op_m   <= md_op;
      a_m    <= md_op_a;
      b_m    <= md_op_b;
    end
  end

  task automatic set_req(input int i, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    req_vld[i] = 1'b1;
    req_op[i*OW +: OW] = op;
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic wait_resp(output logic seen, output logic [N-1:0] v,
                           output logic [31:0] h, output logic [31:0] l);
    seen = 1'b0; v = '0; h = '0; l = '0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk); #1;
      if (resp_vld != '0) begin
        seen = 1'b1; v = resp_vld; h = resp_h; l = resp_l;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_vld = '0; req_kill = '0; req_op = '0; req_a = '0; req_b = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (req_rdy !== 2'b00 || resp_vld !== 2'b00) begin
      failures++; $display("FAIL reset_hs got rdy=%b resp_vld=%b exp 00 00", req_rdy, resp_vld); end
    checks++; if (resp_h !== 32'h0 || resp_l !== 32'h0) begin
      failures++; $display("FAIL reset_resp got h=%h l=%h exp 0 0", resp_h, resp_l); end
    checks++; if (md_op_vld !== 1'b0 || md_op_kill !== 1'b0) begin
      failures++; $display("FAIL reset_md got vld=%b kill=%b exp 0 0", md_op_vld, md_op_kill); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_single_mul();
    int nrdy, nresp;
    logic [N-1:0] rv;
    logic [31:0] rh, rl;
    nrdy = 0; nresp = 0; rv = '0; rh = 'x; rl = 'x;
    @(negedge clk); set_req(0, MUL, 6, 7); #1;
    checks++; if (req_rdy !== 2'b01) begin
      failures++; $display("FAIL t1_grant got=%b exp=01", req_rdy); end
    checks++; if (md_op_vld !== 1'b1 || md_op !== MUL || md_op_a !== 32'd6 || md_op_b !== 32'd7) begin
      failures++; $display("FAIL t1_issue got vld=%b op=%0d a=%0d b=%0d exp 1 0 6 7", md_op_vld, md_op, md_op_a, md_op_b); end
    @(negedge clk); req_vld = '0;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (req_rdy != '0) nrdy++;
      if (resp_vld != '0) begin nresp++; rv = resp_vld; rh = resp_h; rl = resp_l; end
      @(negedge clk);
    end
    checks++; if (nrdy != 0 || nresp != 1) begin
      failures++; $display("FAIL t1_counts got rdy=%0d resp=%0d exp 0 1", nrdy, nresp); end
    checks++; if (rv !== 2'b01) begin
      failures++; $display("FAIL t1_resp_vld got=%b exp=01", rv); end
    checks++; if (rl !== 32'd42 || rh !== 32'd0) begin
      failures++; $display("FAIL t1_result got h=%0d l=%0d exp 0 42", rh, rl); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] gr [3];
    logic [N-1:0] rvat [3];
    int ng;
    logic got1;
    logic [31:0] h1, l1;
    ng = 0; got1 = 1'b0; h1 = 'x; l1 = 'x;
    for (int i = 0; i < 3; i++) begin gr[i] = '0; rvat[i] = '0; end
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    set_req(0, MUL, 6, 7); set_req(1, DIVU, 100, 7);
    for (int c = 0; c < 60; c++) begin
      #1;
      if (req_rdy != '0 && ng < 3) begin gr[ng] = req_rdy; rvat[ng] = resp_vld; ng++; end
      if (resp_vld == 2'b10) begin got1 = 1'b1; h1 = resp_h; l1 = resp_l; end
      @(negedge clk);
      if (ng >= 3) req_vld = '0;
    end
    checks++; if (ng != 3 || gr[0] !== 2'b01 || gr[1] !== 2'b10 || gr[2] !== 2'b01) begin
      failures++; $display("FAIL t2_order got n=%0d %b %b %b exp 3 01 10 01", ng, gr[0], gr[1], gr[2]); end
    checks++; if (rvat[2] !== 2'b10) begin
      failures++; $display("FAIL t2_back_to_back got resp_vld=%b at grant exp=10", rvat[2]); end
    checks++; if (!got1 || l1 !== 32'd14 || h1 !== 32'd2) begin
      failures++; $display("FAIL t2_divu got seen=%b l=%0d h=%0d exp 1 14 2", got1, l1, h1); end
  endtask

  task automatic test_kill_owner();
    int nresp;
    logic seen;
    logic [N-1:0] v;
    logic [31:0] h, l;
    nresp = 0;
    @(negedge clk); set_req(1, DIV, -7, 2); #1;
    checks++; if (req_rdy !== 2'b10) begin
      failures++; $display("FAIL t3_grant got=%b exp=10", req_rdy); end
    @(negedge clk); req_vld = '0;
    repeat (4) @(negedge clk);
    req_kill = 2'b10; #1;
    checks++; if (md_op_kill !== 1'b1) begin
      failures++; $display("FAIL t3_kill got=%b exp=1", md_op_kill); end
    @(negedge clk); req_kill = '0; #1;
    checks++; if (md_op_kill !== 1'b0) begin
      failures++; $display("FAIL t3_kill_pulse got=%b exp=0", md_op_kill); end
    for (int c = 0; c < 20; c++) begin
      if (resp_vld != '0) nresp++;
      @(negedge clk); #1;
    end
    checks++; if (nresp != 0) begin
      failures++; $display("FAIL t3_no_resp got=%0d pulses exp=0", nresp); end
    set_req(0, MUL, 3, 4);
    @(negedge clk); req_vld = '0;
    wait_resp(seen, v, h, l);
    checks++; if (!seen || v !== 2'b01 || l !== 32'd12) begin
      failures++; $display("FAIL t3_next_op got seen=%b vld=%b l=%0d exp 1 01 12", seen, v, l); end
  endtask

  task automatic test_kill_nonowner();
    logic seen;
    logic [N-1:0] v;
    logic [31:0] h, l;
    @(negedge clk); set_req(0, MUL, 5, 5); req_kill = 2'b01; #1;
    checks++; if (req_rdy !== 2'b00 || md_op_vld !== 1'b0) begin
      failures++; $display("FAIL kill_idle got rdy=%b vld=%b exp 00 0", req_rdy, md_op_vld); end
    set_req(1, MULHU, 32'hFFFF_FFFF, 2); #1;
    checks++; if (req_rdy !== 2'b10) begin
      failures++; $display("FAIL kill_mask got=%b exp=10", req_rdy); end
    @(negedge clk); req_vld = '0; #1;
    checks++; if (md_op_kill !== 1'b0) begin
      failures++; $display("FAIL kill_nonowner got=%b exp=0", md_op_kill); end
    @(negedge clk); req_kill = '0;
    wait_resp(seen, v, h, l);
    checks++; if (!seen || v !== 2'b10 || h !== 32'd1 || l !== 32'hFFFF_FFFE) begin
      failures++; $display("FAIL kill_nonowner_resp got seen=%b vld=%b h=%h l=%h exp 1 10 1 fffffffe", seen, v, h, l); end
  endtask

  task automatic test_kill_at_completion();
    int nresp;
    nresp = 0;
    @(negedge clk); set_req(0, MUL, 2, 3);
    @(negedge clk); req_vld = '0;
    for (int c = 0; c < 30 && !md_result_vld; c++) @(negedge clk);
    checks++; if (md_result_vld !== 1'b1) begin
      failures++; $display("FAIL t4_result_seen got=%b exp=1", md_result_vld); end
    req_kill = 2'b01; #1;
    checks++; if (md_op_kill !== 1'b1) begin
      failures++; $display("FAIL t4_kill got=%b exp=1", md_op_kill); end
    @(negedge clk); req_kill = '0;
    for (int c = 0; c < 10; c++) begin
      #1; if (resp_vld != '0) nresp++;
      @(negedge clk);
    end
    checks++; if (nresp != 0) begin
      failures++; $display("FAIL t4_no_resp got=%0d pulses exp=0", nresp); end
    set_req(1, MUL, 1, 1); #1;
    checks++; if (req_rdy !== 2'b10) begin
      failures++; $display("FAIL t4_idle got rdy=%b exp=10", req_rdy); end
    @(negedge clk); req_vld = '0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int nresp;
    nresp = 0;
    @(negedge clk); set_req(0, MUL, 9, 9);
    @(negedge clk); req_vld = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    checks++; if (resp_vld !== 2'b00 || req_rdy !== 2'b00) begin
      failures++; $display("FAIL t5_hs got resp_vld=%b rdy=%b exp 00 00", resp_vld, req_rdy); end
    checks++; if (md_op_vld !== 1'b0 || md_op_kill !== 1'b0) begin
      failures++; $display("FAIL t5_md got vld=%b kill=%b exp 0 0", md_op_vld, md_op_kill); end
    checks++; if (resp_h !== 32'h0 || resp_l !== 32'h0) begin
      failures++; $display("FAIL t5_resp got h=%h l=%h exp 0 0", resp_h, resp_l); end
    for (int c = 0; c < 20; c++) begin
      if (resp_vld != '0) nresp++;
      @(negedge clk); #1;
    end
    checks++; if (nresp != 0) begin
      failures++; $display("FAIL t5_no_resp got=%0d pulses exp=0", nresp); end
  endtask

`ifdef HAZARD3_MULDIV_ARB_REUSE_EN
  task automatic test_reuse();
    logic seen;
    logic [N-1:0] v;
    logic [31:0] h, l;
    @(negedge clk); set_req(0, MULH, -3, 5);
    @(negedge clk); req_vld = '0;
    wait_resp(seen, v, h, l);
    checks++; if (!seen || h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFF1) begin
      failures++; $display("FAIL t6_mulh got seen=%b h=%h l=%h exp 1 ffffffff fffffff1", seen, h, l); end
    @(negedge clk); set_req(0, MUL, -3, 5); #1;
    checks++; if (req_rdy !== 2'b01 || md_op_vld !== 1'b0) begin
      failures++; $display("FAIL t6_hit got rdy=%b md_vld=%b exp 01 0", req_rdy, md_op_vld); end
    @(negedge clk); req_vld = '0; #1;
    checks++; if (resp_vld !== 2'b01 || resp_l !== 32'hFFFF_FFF1) begin
      failures++; $display("FAIL t6_reuse got vld=%b l=%h exp 01 fffffff1", resp_vld, resp_l); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_mul();
    test_round_robin();
    test_kill_owner();
    test_kill_nonowner();
    test_kill_at_completion();
    test_reset_mid();
`ifdef HAZARD3_MULDIV_ARB_REUSE_EN
    test_reuse();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
